// File: rtl/mvm_stream_8_4_16.sv
// Streaming matrix-vector engine: loads an MxN signed weight matrix, then turns each
// N-element input vector into M saturated (optionally ReLU'd) dot products.
module mvm_stream_8_4_16 #(
    parameter int M    = 8,
    parameter int N    = 4,
    parameter int T    = 16,
    parameter int RELU = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         input_valid,
    output logic         input_ready,
    input  logic [T-1:0] input_data,
    output logic         output_valid,
    input  logic         output_ready,
    output logic [T-1:0] output_data
);
    localparam int AW  = 2*T + $clog2(N);
    localparam int WPW = (M*N > 1) ? $clog2(M*N) : 1;
    localparam int KW  = (N > 1) ? $clog2(N) : 1;
    localparam int RW  = (M > 1) ? $clog2(M) : 1;
    localparam logic [WPW-1:0] LAST_W = WPW'(M*N-1);
    localparam logic [KW-1:0]  LAST_K = KW'(N-1);
    localparam logic [RW-1:0]  LAST_R = RW'(M-1);
    localparam logic signed [AW-1:0] ACC_MAX = {{(AW-T+1){1'b0}}, {(T-1){1'b1}}};
    localparam logic signed [AW-1:0] ACC_MIN = {{(AW-T+1){1'b1}}, {(T-1){1'b0}}};

    typedef enum logic [2:0] {
        S_LOAD_W = 3'd0,
        S_LOAD_X = 3'd1,
        S_MAC    = 3'd2,
        S_SAT    = 3'd3,
        S_OUT    = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic                   in_rdy_q, in_rdy_d;
    logic                   out_vld_q, out_vld_d;
    logic [T-1:0]           out_data_q;
    logic [WPW-1:0]         wptr_q;
    logic [KW-1:0]          k_q;
    logic [RW-1:0]          row_q;
    logic signed [AW-1:0]   acc_q;
    logic signed [T-1:0]    w_q [M*N];
    logic signed [T-1:0]    x_q [N];
    logic signed [2*T-1:0]  prod_s;
    logic signed [T-1:0]    sat_s;
    logic signed [T-1:0]    res_s;
    logic                   in_acc_s;
    logic                   out_hs_s;

    assign in_acc_s     = input_valid && in_rdy_q;
    assign out_hs_s     = out_vld_q && output_ready;
    assign input_ready  = in_rdy_q;
    assign output_valid = out_vld_q;
    assign output_data  = out_data_q;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state_q <= S_LOAD_W;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD_W: if (in_acc_s && wptr_q == LAST_W) state_d = S_LOAD_X; else state_d = state_q;
            S_LOAD_X: if (in_acc_s && k_q == LAST_K)    state_d = S_MAC;    else state_d = state_q;
            S_MAC:    if (k_q == LAST_K)                state_d = S_SAT;    else state_d = state_q;
            S_SAT:    state_d = S_OUT;
            S_OUT: begin
                if (out_hs_s) state_d = (row_q == LAST_R) ? S_LOAD_X : S_MAC;
                else          state_d = state_q;
            end
            default:  state_d = S_LOAD_W;
        endcase
    end

    // Output decode: handshake flags are registered from the upcoming state
    always_comb begin
        in_rdy_d  = (state_d == S_LOAD_W) || (state_d == S_LOAD_X);
        out_vld_d = (state_d == S_OUT);
    end

    // Handshake flag registers; held low through reset so nothing moves until release
    always_ff @(posedge clk) begin
        if (!reset) begin
            in_rdy_q  <= 1'b0;
            out_vld_q <= 1'b0;
        end else begin
            in_rdy_q  <= in_rdy_d;
            out_vld_q <= out_vld_d;
        end
    end

    // Multiply, clamp to T bits, then optional ReLU
    always_comb begin
        prod_s = (2*T)'(w_q[wptr_q]) * (2*T)'(x_q[k_q]);
        if (acc_q > ACC_MAX)      sat_s = {1'b0, {(T-1){1'b1}}};
        else if (acc_q < ACC_MIN) sat_s = {1'b1, {(T-1){1'b0}}};
        else                      sat_s = acc_q[T-1:0];
        if (RELU != 0 && sat_s[T-1]) res_s = '0;
        else                         res_s = sat_s;
    end

    // Counters, accumulator and result register; the weight pointer walks all rows during MAC
    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr_q     <= '0;
            k_q        <= '0;
            row_q      <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
        end else begin
            case (state_q)
                S_LOAD_W: if (in_acc_s) wptr_q <= (wptr_q == LAST_W) ? '0 : wptr_q + WPW'(1);
                S_LOAD_X: if (in_acc_s) begin
                    k_q <= (k_q == LAST_K) ? '0 : k_q + KW'(1);
                    if (k_q == LAST_K) begin
                        acc_q <= '0;
                        row_q <= '0;
                    end
                end
                S_MAC: begin
                    acc_q  <= acc_q + AW'(prod_s);
                    k_q    <= (k_q == LAST_K) ? '0 : k_q + KW'(1);
                    wptr_q <= (wptr_q == LAST_W) ? '0 : wptr_q + WPW'(1);
                end
                S_SAT:    out_data_q <= res_s;
                S_OUT: if (out_hs_s) begin
                    acc_q <= '0;
                    row_q <= (row_q == LAST_R) ? '0 : row_q + RW'(1);
                end
                default: ;
            endcase
        end
    end

    // Weight and vector storage; a full reload always precedes use, so no reset needed
    always_ff @(posedge clk) begin
        if (reset && in_acc_s && state_q == S_LOAD_W) w_q[wptr_q] <= input_data;
        if (reset && in_acc_s && state_q == S_LOAD_X) x_q[k_q]    <= input_data;
    end
endmodule

// File: tb/tb_mvm_stream_8_4_16.sv
// Bench for mvm_stream_8_4_16: a ReLU and a linear instance share stimulus and are
// scored against a word-counting arithmetic model of the matrix-vector product.
module tb_mvm_stream_8_4_16;
    localparam int M = 8;
    localparam int N = 4;
    localparam int T = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        input_valid = 1'b0;
    logic [15:0] input_data = 16'd0;
    logic        output_ready = 1'b0;
    logic        input_ready_r, output_valid_r, input_ready_l, output_valid_l;
    logic [15:0] output_data_r, output_data_l;

    always #5 clk = ~clk;

    mvm_stream_8_4_16 #(.M(M), .N(N), .T(T), .RELU(1)) u_relu (
        .clk(clk), .reset(reset), .input_valid(input_valid), .input_ready(input_ready_r),
        .input_data(input_data), .output_valid(output_valid_r), .output_ready(output_ready),
        .output_data(output_data_r));

    mvm_stream_8_4_16 #(.M(M), .N(N), .T(T), .RELU(0)) u_lin (
        .clk(clk), .reset(reset), .input_valid(input_valid), .input_ready(input_ready_l),
        .input_data(input_data), .output_valid(output_valid_l), .output_ready(output_ready),
        .output_data(output_data_l));

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int n_out = 0;
    int rdy_pct = 100;
    int in_stall_pct = 0;
    int last_acc_edge = 0;
    logic [15:0] exp_r[$];
    logic [15:0] exp_l[$];
    int rise_q[$];

    // reference model state
    int nw = 0;
    int xi = 0;
    logic signed [15:0] wm [M][N];
    logic signed [15:0] xv [N];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic void model_clear();
        nw = 0;
        xi = 0;
        exp_r.delete();
        exp_l.delete();
    endfunction

    function automatic void model_accept(input logic [15:0] d);
        longint s;
        if (nw < M*N) begin
            wm[nw / N][nw % N] = d;
            nw++;
        end else begin
            xv[xi] = d;
            xi++;
            if (xi == N) begin
                xi = 0;
                for (int m = 0; m < M; m++) begin
                    s = 0;
                    for (int k = 0; k < N; k++) s += longint'(wm[m][k]) * longint'(xv[k]);
                    if (s > 32767) s = 32767;
                    else if (s < -32768) s = -32768;
                    exp_l.push_back(16'(s));
                    exp_r.push_back((s < 0) ? 16'd0 : 16'(s));
                end
            end
        end
    endfunction

    // Called at a negedge; returns at the negedge after the word was taken.
    task automatic push_word(input logic [15:0] d);
        int g;
        while (in_stall_pct > 0 && $urandom_range(99) < in_stall_pct) begin
            input_valid = 1'b0;
            input_data  = 16'($urandom);
            @(negedge clk);
        end
        input_valid = 1'b1;
        input_data  = d;
        g = 0;
        while (!input_ready_r && g < 5000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 5000) begin
            chk("push_timeout", 32'd0, 32'd1);
        end else begin
            model_accept(d);
            last_acc_edge = cyc + 1;
        end
        @(negedge clk);
        input_valid = 1'b0;
        input_data  = 16'($urandom);
    endtask

    task automatic push_vec(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input logic [15:0] e);
        push_word(a); push_word(b); push_word(c); push_word(e);
    endtask

    task automatic push_const_weights(input logic [15:0] v);
        for (int i = 0; i < M*N; i++) push_word(v);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        input_valid = 1'b0;
        model_clear();
        @(posedge clk); #1;
        chk("rst_in_ready", input_ready_r, 0);
        chk("rst_out_valid", output_valid_r, 0);
        chk("rst_out_data", output_data_r, 0);
        chk("rst_out_valid_lin", output_valid_l, 0);
        chk("rst_out_data_lin", output_data_l, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("release_in_ready", input_ready_r, 1);
        @(negedge clk);
    endtask

    // Returns one time unit after the posedge carrying handshake number 'target'.
    task automatic wait_outputs(input int target);
        int g = 0;
        do begin
            @(posedge clk); #1;
            g++;
        end while (n_out < target && g < 5000);
        if (n_out < target) chk("output_timeout", n_out, target);
    endtask

    // Output side: random ready, scoreboard compare, hold and busy checks.
    initial begin
        logic        pend;
        logic        pvalid;
        logic [15:0] pdata;
        pend = 1'b0; pvalid = 1'b0; pdata = 16'd0;
        forever begin
            @(negedge clk);
            output_ready = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(99) < rdy_pct);
            if (!reset) begin
                pend = 1'b0;
                pvalid = 1'b0;
            end else begin
                if (pend) begin
                    chk("hold_valid", output_valid_r, 1);
                    chk("hold_data", output_data_r, pdata);
                end
                if (output_valid_r && !pvalid) rise_q.push_back(cyc);
                if (output_valid_r) chk("busy_in_ready", input_ready_r, 0);
                if (output_valid_l) chk("busy_in_ready_lin", input_ready_l, 0);
                if (output_valid_r && output_ready) begin
                    if (exp_r.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
                    else chk("out_relu", output_data_r, exp_r.pop_front());
                    n_out++;
                end
                if (output_valid_l && output_ready) begin
                    if (exp_l.size() == 0) chk("unexpected_out_lin", 32'd1, 32'd0);
                    else chk("out_lin", output_data_l, exp_l.pop_front());
                end
                pend   = output_valid_r && !output_ready;
                pdata  = output_data_r;
                pvalid = output_valid_r;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] lit_a [8];
        logic [15:0] lit_b [8];
        logic [15:0] d0;
        int base;
        int g;
        lit_a = '{16'd5, 16'hFFFA, 16'd7, 16'hFFF8, 16'd5, 16'hFFFA, 16'd7, 16'hFFF8};
        lit_b = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd1, 16'd2, 16'd3, 16'd4};

        // Basic dot product with latency checks
        do_reset();
        rdy_pct = 100;
        in_stall_pct = 0;
        push_const_weights(16'd1);
        rise_q.delete();
        push_vec(16'd1, 16'd2, 16'd3, 16'd4);
        for (int i = 0; i < M; i++) chk("lit_basic", exp_r[i], 16'd10);
        base = n_out;
        wait_outputs(base + M);
        chk("ready_after_last_row", input_ready_r, 1);
        chk("rise_count", rise_q.size(), M);
        if (rise_q.size() == M) begin
            chk("first_latency", rise_q[0] - last_acc_edge, N + 1);
            for (int i = 1; i < M; i++) chk("row_gap", rise_q[i] - rise_q[i-1], N + 2);
        end
        @(negedge clk);

        // Weight persistence and row order
        do_reset();
        for (int m = 0; m < M; m++)
            for (int k = 0; k < N; k++) push_word((k == m % N) ? 16'd1 : 16'd0);
        push_vec(16'd5, 16'hFFFA, 16'd7, 16'hFFF8);
        for (int i = 0; i < M; i++) chk("lit_order_lin", exp_l[i], lit_a[i]);
        chk("lit_order_relu", exp_r[1], 16'd0);
        base = n_out;
        wait_outputs(base + M);
        @(negedge clk);
        push_vec(16'd1, 16'd2, 16'd3, 16'd4);
        for (int i = 0; i < M; i++) chk("lit_persist_lin", exp_l[i], lit_b[i]);
        base = n_out;
        wait_outputs(base + M);
        @(negedge clk);

        // Backpressure: hold ready low for 5 cycles with a result pending
        rdy_pct = 0;
        push_vec(16'd1, 16'd2, 16'd3, 16'd4);
        g = 0;
        while (!output_valid_r && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("bp_valid_seen", output_valid_r, 1);
        d0 = output_data_r;
        chk("bp_first_data", d0, 16'd1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", output_valid_r, 1);
            chk("bp_data", output_data_r, d0);
            chk("bp_in_ready", input_ready_r, 0);
        end
        rdy_pct = 100;
        base = n_out;
        wait_outputs(base + M);
        @(negedge clk);

        // Saturation and ReLU
        do_reset();
        push_const_weights(16'h7FFF);
        push_vec(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        chk("lit_sat_pos_relu", exp_r[0], 16'h7FFF);
        chk("lit_sat_pos_lin", exp_l[0], 16'h7FFF);
        base = n_out;
        wait_outputs(base + M);
        @(negedge clk);
        do_reset();
        push_const_weights(16'h8000);
        push_vec(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        chk("lit_sat_neg_lin", exp_l[0], 16'h8000);
        chk("lit_sat_neg_relu", exp_r[0], 16'h0000);
        base = n_out;
        wait_outputs(base + M);
        @(negedge clk);

        // Mid-output reset after 3 of 8 results, then full reload
        do_reset();
        for (int i = 0; i < M*N; i++) push_word(16'($urandom_range(0, 127)) - 16'd64);
        push_vec(16'd100, 16'd200, 16'hFF00, 16'd50);
        base = n_out;
        wait_outputs(base + 3);
        do_reset();
        for (int i = 0; i < M*N; i++) push_word(16'($urandom_range(0, 127)) - 16'd64);
        push_vec(16'($urandom_range(0, 511)) - 16'd256, 16'($urandom_range(0, 511)) - 16'd256,
                 16'($urandom_range(0, 511)) - 16'd256, 16'($urandom_range(0, 511)) - 16'd256);
        base = n_out;
        wait_outputs(base + M);
        chk("reload_drained", exp_r.size(), 0);
        @(negedge clk);

        // Random traffic on both interfaces with the weights above
        rdy_pct = 50;
        in_stall_pct = 50;
        for (int v = 0; v < 1000; v++) begin
            for (int k = 0; k < N; k++) push_word(16'($urandom_range(0, 511)) - 16'd256);
        end
        g = 0;
        while ((exp_r.size() != 0 || exp_l.size() != 0) && g < 20000) begin
            @(negedge clk);
            g++;
        end
        chk("drain_relu", exp_r.size(), 0);
        chk("drain_lin", exp_l.size(), 0);
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
